// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter slice.
//   state_t       : arbiter FSM state (IDLE, BUSY, DONE)
//   REQ_*         : requester index constants
//   idx_width()   : width of an index into n requesters (at least 1 bit)
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int REQ_ICACHE   = 0;
  localparam int REQ_DCACHE   = 1;
  localparam int REQ_UNCACHED = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the cache-side requesters, the arbiter and the
// external bus port.
//   Requester side : req_i, we_i, addr_i, wdata_i (in)  rsp_o, rdata_o, err_o (out)
//   Bus side       : cyc_o, stb_o, we_o, addr_o, data_o (out)  ack_i, data_i (in)
// Handshake: a requester raises req_i[n] with stable we/addr/wdata and keeps
// it high until it sees its one-cycle rsp_o[n] pulse; rdata_o and err_o are
// only meaningful in that cycle. On the bus, cyc_o/stb_o stay high with stable
// we/addr/data until ack_i is sampled high (or the watchdog fires).
// modport master : the arbiter's view.  modport slave : the environment's view.
interface bus_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0]                 we_i;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]                 rsp_o;
  logic [DATA_WIDTH-1:0]              rdata_o;
  logic                               err_o;

  logic                               cyc_o;
  logic                               stb_o;
  logic                               we_o;
  logic [ADDR_WIDTH-1:0]              addr_o;
  logic [DATA_WIDTH-1:0]              data_o;
  logic                               ack_i;
  logic [DATA_WIDTH-1:0]              data_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i,
    output rsp_o, rdata_o, err_o,
    output cyc_o, stb_o, we_o, addr_o, data_o,
    input  ack_i, data_i
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i,
    input  rsp_o, rdata_o, err_o,
    input  cyc_o, stb_o, we_o, addr_o, data_o,
    output ack_i, data_i
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. Priority starts at (last+1) mod NUM_REQ
// and wraps around, so the most recent winner has the lowest priority.
//   req   : request vector
//   last  : index of the previous winner
//   grant : one-hot winner (zero when no request)
//   idx   : winner index
//   valid : at least one request present
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single external bus master port between the I-cache, D-cache
// and uncached requesters. Bus outputs are registered, the winner holds the
// bus until ack_i, and a watchdog ends a stuck cycle with an error response.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester and bus signals (bus_arbiter_if.master)
//   dbg_state  : current FSM state
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter_if.master     bus,
  output state_t            dbg_state
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Value seen in the last allowed BUSY cycle; the cycle is dropped on the
  // edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t state_q, state_n;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;

  logic [NUM_REQ-1:0]    grant_oh_q;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      last_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cyc_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REQ-1:0]    rsp_q;
  logic                  err_q;

  logic                  load;
  logic                  take_ack;
  logic                  expire;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (bus.req_i),
    .last  (last_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // ack_i is checked before the watchdog so an ack on the expiry cycle wins.
  always_comb begin
    state_n  = state_q;
    load     = 1'b0;
    take_ack = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (bus.ack_i) begin
          take_ack = 1'b1;
          state_n  = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          expire  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_oh_q <= '0;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      rsp_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp_q <= '0;
      err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (load) begin
          cyc_q      <= 1'b1;
          we_q       <= bus.we_i[pick_idx];
          addr_q     <= bus.addr_i[pick_idx];
          data_q     <= bus.wdata_i[pick_idx];
          grant_q    <= pick_idx;
          grant_oh_q <= pick_oh;
          cnt_q      <= '0;
        end else begin
          cyc_q  <= 1'b0;
          we_q   <= 1'b0;
          addr_q <= '0;
          data_q <= '0;
        end
      end
      if (take_ack) begin
        rdata_q <= bus.data_i;
        cyc_q   <= 1'b0;
        we_q    <= 1'b0;
        rsp_q   <= grant_oh_q;
      end else if (expire) begin
        rdata_q <= '0;
        cyc_q   <= 1'b0;
        we_q    <= 1'b0;
        rsp_q   <= grant_oh_q;
        err_q   <= 1'b1;
      end else if (state_q == BUSY && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == DONE) last_q <= grant_q;
    end
  end

  assign bus.cyc_o   = cyc_q;
  assign bus.stb_o   = cyc_q;
  assign bus.we_o    = we_q;
  assign bus.addr_o  = addr_q;
  assign bus.data_o  = data_q;
  assign bus.rdata_o = rdata_q;
  assign bus.rsp_o   = rsp_q;
  assign bus.err_o   = err_q;
  assign dbg_state   = state_q;

endmodule
